// File: rtl/dmem_if.sv
// Request/response channel between the memory-access stage (master) and the
// data-memory responder (slave).
interface dmem_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_error;

   modport master (
      output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_error
   );

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_error
   );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle, byte-addressable little-endian data memory of 64-bit words.
// One request is accepted in IDLE, committed after LATENCY cycles, then held in RESP.
module dmem_responder #(
   parameter int DEPTH_WORDS = 128,
   parameter int LATENCY     = 2
) (
   input  logic   clk,
   input  logic   reset,
   dmem_if.slave  bus
);
   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]  state;
   logic [3:0]  cnt;
   logic        a_write;
   logic [1:0]  a_size;
   logic        a_unsigned;
   logic [63:0] a_addr;
   logic [63:0] a_wdata;
   logic [63:0] rdata_q;
   logic        error_q;

   // NOTE: the array has no reset branch; contents survive reset and it maps to plain RAM.
   logic [63:0] mem [DEPTH_WORDS];

   logic [IDX_W-1:0] idx;
   logic [5:0]       shamt;
   logic             acc_error;
   logic             commit;
   logic [63:0]      cur_word;
   logic [63:0]      field;
   logic [63:0]      load_val;
   logic [63:0]      lane_mask;
   logic [63:0]      bit_mask;
   logic [63:0]      merged;
   logic             misalign;
   logic             sext;

   assign idx    = a_addr[IDX_W+2:3];
   assign shamt  = {a_addr[2:0], 3'b000};
   assign commit = (state == BUSY) && (cnt == 4'd0);

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      misalign  = 1'b0;
      lane_mask = '1;
      load_val  = '0;
      sext      = ~a_unsigned;
      case (a_size)
         2'd0: begin misalign = 1'b0;           lane_mask = 64'h0000_0000_0000_00FF; end
         2'd1: begin misalign = a_addr[0];      lane_mask = 64'h0000_0000_0000_FFFF; end
         2'd2: begin misalign = |a_addr[1:0];   lane_mask = 64'h0000_0000_FFFF_FFFF; end
         default: begin misalign = |a_addr[2:0]; lane_mask = '1; end
      endcase
      acc_error = misalign || (a_addr[63:3] >= 61'(DEPTH_WORDS));

      cur_word = mem[idx];
      field    = cur_word >> shamt;
      case (a_size)
         2'd0:    load_val = {{56{sext & field[7]}},  field[7:0]};
         2'd1:    load_val = {{48{sext & field[15]}}, field[15:0]};
         2'd2:    load_val = {{32{sext & field[31]}}, field[31:0]};
         default: load_val = field;
      endcase

      bit_mask = lane_mask << shamt;
      merged   = (cur_word & ~bit_mask) | ((a_wdata << shamt) & bit_mask);
   end

   assign bus.req_ready  = (state == IDLE) && !reset;
   assign bus.resp_valid = (state == RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_error = error_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         rdata_q <= '0;
         error_q <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.req_valid) begin
               cnt   <= 4'(LATENCY - 1);
               state <= BUSY;
            end
            BUSY: if (cnt != 4'd0) begin
               cnt <= cnt - 4'd1;
            end else begin
               state   <= RESP;
               error_q <= acc_error;
               rdata_q <= (acc_error || a_write) ? 64'd0 : load_val;
            end
            RESP: if (bus.resp_ready) begin
               state   <= IDLE;
               rdata_q <= '0;
               error_q <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Request capture and array writes need no reset: they are only consumed after a handshake.
   always_ff @(posedge clk) begin
      if (!reset && state == IDLE && bus.req_valid) begin
         a_write    <= bus.req_write;
         a_size     <= bus.req_size;
         a_unsigned <= bus.req_unsigned;
         a_addr     <= bus.req_addr;
         a_wdata    <= bus.req_wdata;
      end
      if (!reset && commit && a_write && !acc_error) begin
         mem[idx] <= merged;
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: data path, errors, backpressure, reset and throughput.
module tb_dmem_responder;
   logic clk;
   logic reset;
   int   cyc;
   int   n_tests;
   int   n_fail;

   dmem_if bus_a ();
   dmem_if bus_b ();

   dmem_responder #(.DEPTH_WORDS(128), .LATENCY(2)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
   dmem_responder #(.DEPTH_WORDS(128), .LATENCY(1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One full transaction on bus_a; lat is cycles from handshake to first resp_valid.
   task automatic xact(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wd,
                       output logic [63:0] rd, output logic er, output int lat);
      int c0;
      int n;
      @(negedge clk);
      bus_a.req_valid    = 1'b1;
      bus_a.req_write    = w;
      bus_a.req_size     = sz;
      bus_a.req_unsigned = uns;
      bus_a.req_addr     = addr;
      bus_a.req_wdata    = wd;
      n = 0;
      while (!bus_a.req_ready && n < 50) begin @(negedge clk); n++; end
      c0 = cyc;
      @(negedge clk);
      bus_a.req_valid = 1'b0;
      n = 0;
      while (!bus_a.resp_valid && n < 50) begin @(negedge clk); n++; end
      lat = cyc - c0;
      rd  = bus_a.resp_rdata;
      er  = bus_a.resp_error;
      bus_a.resp_ready = 1'b1;
      @(negedge clk);
      bus_a.resp_ready = 1'b0;
   endtask

   logic [63:0] rd;
   logic        er;
   int          lat;
   int          acc[3];
   int          na;
   int          n;

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b1;
      {bus_a.req_valid, bus_a.req_write, bus_a.req_unsigned, bus_a.resp_ready} = '0;
      {bus_b.req_valid, bus_b.req_write, bus_b.req_unsigned, bus_b.resp_ready} = '0;
      bus_a.req_size = 2'd0; bus_a.req_addr = '0; bus_a.req_wdata = '0;
      bus_b.req_size = 2'd0; bus_b.req_addr = '0; bus_b.req_wdata = '0;

      repeat (2) @(negedge clk);
      check("ready_in_reset", 64'(bus_a.req_ready), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      check("rst_ready", 64'(bus_a.req_ready), 64'd1);
      check("rst_valid", 64'(bus_a.resp_valid), 64'd0);
      check("rst_rdata", bus_a.resp_rdata, 64'd0);
      check("rst_error", 64'(bus_a.resp_error), 64'd0);

      xact(1'b1, 2'd3, 1'b0, 64'h10, 64'h1122334455667788, rd, er, lat);
      check("st_d_lat", 64'(lat), 64'd3);
      check("st_d_rdata", rd, 64'd0);
      check("st_d_err", 64'(er), 64'd0);
      xact(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, rd, er, lat);
      check("ld_d_lat", 64'(lat), 64'd3);
      check("ld_d_rdata", rd, 64'h1122334455667788);
      check("ld_d_err", 64'(er), 64'd0);

      xact(1'b1, 2'd0, 1'b0, 64'h13, 64'hFFFF_FFFF_FFFF_FF80, rd, er, lat);
      xact(1'b0, 2'd0, 1'b0, 64'h13, 64'd0, rd, er, lat);
      check("ld_b_signed", rd, 64'hFFFF_FFFF_FFFF_FF80);
      xact(1'b0, 2'd0, 1'b1, 64'h13, 64'd0, rd, er, lat);
      check("ld_b_unsigned", rd, 64'h0000_0000_0000_0080);
      xact(1'b0, 2'd3, 1'b0, 64'h10, 64'd0, rd, er, lat);
      check("ld_d_merged", rd, 64'h1122334480667788);
      xact(1'b0, 2'd1, 1'b0, 64'h12, 64'd0, rd, er, lat);
      check("ld_h_signed", rd, 64'hFFFF_FFFF_FFFF_8066);
      xact(1'b0, 2'd2, 1'b0, 64'h14, 64'd0, rd, er, lat);
      check("ld_w_signed_pos", rd, 64'h0000_0000_1122_3344);

      xact(1'b0, 2'd1, 1'b0, 64'h11, 64'd0, rd, er, lat);
      check("misalign_err", 64'(er), 64'd1);
      check("misalign_rdata", rd, 64'd0);
      xact(1'b1, 2'd3, 1'b0, 64'h0, 64'h0000_0000_0000_CAFE, rd, er, lat);
      xact(1'b1, 2'd2, 1'b0, 64'h400, 64'h5555_5555, rd, er, lat);
      check("range_err", 64'(er), 64'd1);
      xact(1'b0, 2'd3, 1'b0, 64'h0, 64'd0, rd, er, lat);
      check("range_no_write", rd, 64'h0000_0000_0000_CAFE);
      check("err_not_sticky", 64'(er), 64'd0);

      // Backpressure: response held while a new request waits.
      @(negedge clk);
      bus_a.req_valid = 1'b1; bus_a.req_write = 1'b0; bus_a.req_size = 2'd3;
      bus_a.req_addr = 64'h10;
      @(negedge clk);
      n = 0;
      while (!bus_a.resp_valid && n < 50) begin @(negedge clk); n++; end
      check("bp_rdata", bus_a.resp_rdata, 64'h1122334480667788);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_hold_valid", 64'(bus_a.resp_valid), 64'd1);
         check("bp_hold_rdata", bus_a.resp_rdata, 64'h1122334480667788);
         check("bp_hold_ready", 64'(bus_a.req_ready), 64'd0);
      end
      bus_a.resp_ready = 1'b1;
      @(negedge clk);
      bus_a.resp_ready = 1'b0;
      check("bp_idle_ready", 64'(bus_a.req_ready), 64'd1);
      check("bp_idle_valid", 64'(bus_a.resp_valid), 64'd0);
      check("bp_idle_rdata", bus_a.resp_rdata, 64'd0);
      @(negedge clk);
      bus_a.req_valid = 1'b0;
      check("bp_next_accepted", 64'(bus_a.req_ready), 64'd0);
      n = 0;
      while (!bus_a.resp_valid && n < 50) begin @(negedge clk); n++; end
      check("bp_next_rdata", bus_a.resp_rdata, 64'h1122334480667788);
      bus_a.resp_ready = 1'b1;
      @(negedge clk);
      bus_a.resp_ready = 1'b0;

      // Reset during BUSY discards the store.
      xact(1'b1, 2'd3, 1'b0, 64'h20, 64'h1111, rd, er, lat);
      @(negedge clk);
      bus_a.req_valid = 1'b1; bus_a.req_write = 1'b1; bus_a.req_size = 2'd3;
      bus_a.req_addr = 64'h20; bus_a.req_wdata = 64'hDEAD;
      @(negedge clk);
      bus_a.req_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      check("busy_rst_valid", 64'(bus_a.resp_valid), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      check("busy_rst_ready", 64'(bus_a.req_ready), 64'd1);
      check("busy_rst_rdata", bus_a.resp_rdata, 64'd0);
      xact(1'b0, 2'd3, 1'b0, 64'h20, 64'd0, rd, er, lat);
      check("busy_rst_discard", rd, 64'h1111);

      // Reset during RESP keeps the committed store.
      @(negedge clk);
      bus_a.req_valid = 1'b1; bus_a.req_write = 1'b1; bus_a.req_size = 2'd3;
      bus_a.req_addr = 64'h28; bus_a.req_wdata = 64'h2222;
      @(negedge clk);
      bus_a.req_valid = 1'b0;
      n = 0;
      while (!bus_a.resp_valid && n < 50) begin @(negedge clk); n++; end
      reset = 1'b1;
      @(negedge clk);
      check("resp_rst_drop", 64'(bus_a.resp_valid), 64'd0);
      reset = 1'b0;
      xact(1'b0, 2'd3, 1'b0, 64'h28, 64'd0, rd, er, lat);
      check("resp_rst_persist", rd, 64'h2222);

      // Throughput with req_valid and resp_ready held high, LATENCY=2.
      @(negedge clk);
      bus_a.req_valid = 1'b1; bus_a.req_write = 1'b0; bus_a.req_size = 2'd3;
      bus_a.req_addr = 64'h10; bus_a.resp_ready = 1'b1;
      na = 0;
      for (int k = 0; k < 40 && na < 3; k++) begin
         if (bus_a.req_valid && bus_a.req_ready) begin acc[na] = cyc; na++; end
         @(negedge clk);
      end
      bus_a.req_valid = 1'b0;
      check("tp2_accepts", 64'(na), 64'd3);
      check("tp2_gap0", 64'(acc[1] - acc[0]), 64'd4);
      check("tp2_gap1", 64'(acc[2] - acc[1]), 64'd4);
      repeat (6) @(negedge clk);
      bus_a.resp_ready = 1'b0;

      // Throughput on the LATENCY=1 instance.
      bus_b.req_valid = 1'b1; bus_b.req_write = 1'b1; bus_b.req_size = 2'd3;
      bus_b.req_addr = 64'h8; bus_b.req_wdata = 64'h77; bus_b.resp_ready = 1'b1;
      na = 0;
      for (int k = 0; k < 40 && na < 3; k++) begin
         if (bus_b.req_valid && bus_b.req_ready) begin acc[na] = cyc; na++; end
         @(negedge clk);
      end
      bus_b.req_valid = 1'b0;
      check("tp1_accepts", 64'(na), 64'd3);
      check("tp1_gap0", 64'(acc[1] - acc[0]), 64'd3);
      check("tp1_gap1", 64'(acc[2] - acc[1]), 64'd3);
      repeat (4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
